can_rec_arbiter: RTL and testbench
==================================

CAN_REC_ARBITER -- requirements
Module: can_rec_arbiter

Interface
REQ-001 SHALL have parameter READ_LAT, default 2: cycles from can_rec_select change to valid rec_data_in; legal range 1..15.
REQ-002 SHALL have port clk  input  1  system clock, 40 MHz.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port n_buses  input  5  highest enabled bus index; buses above it are ignored.
REQ-005 SHALL have port irq_can_rec  input  32  per-bus level "received frame pending" from the CAN controllers.
REQ-006 SHALL have port rec_data_in  input  76  frame of the bus addressed by can_rec_select, via an external mux.
REQ-007 SHALL have port can_rec_select  output  5  index of the bus being served.
REQ-008 SHALL have port rec_ack  output  32  one-hot, one-cycle pulse that clears the served bus's pending flag.
REQ-009 SHALL have port data_rec_uplink  output  76  frame toward the e-link transmitter.
REQ-010 SHALL have port uplink_valid  output  1  data_rec_uplink holds an unconsumed frame.
REQ-011 SHALL have port uplink_ready  input  1  e-link transmitter accepts a frame this cycle.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port rec_cnt  output  16  count of frames delivered; wraps from 0xFFFF to 0.

Function
REQ-014 SHALL implement the FSM IDLE -> READ -> SEND -> ACK -> IDLE, with one state register.
REQ-015 IDLE: SHALL compute eligible = irq_can_rec masked to indices 0..n_buses; if any bit is set, SHALL load can_rec_select with the round-robin winner and go to READ.
REQ-016 Round-robin SHALL search upward from last_served+1, wrap past n_buses to 0, and end at last_served, so last_served has the lowest priority.
REQ-017 last_served SHALL reset to n_buses-equivalent 31, so bus 0 wins first after reset.
REQ-018 If last_served > n_buses (n_buses lowered at run time), the search SHALL start at 0.
REQ-019 READ: SHALL count READ_LAT cycles with a 4-bit counter, then register rec_data_in into data_rec_uplink, assert uplink_valid and go to SEND.
REQ-020 SEND: uplink_valid and data_rec_uplink SHALL stay stable until a cycle with uplink_ready=1; on that cycle SHALL go to ACK with uplink_valid=0 on the next cycle.
REQ-021 uplink_ready asserted while uplink_valid=0 SHALL have no effect.
REQ-022 ACK: SHALL pulse rec_ack[can_rec_select] for exactly one cycle, increment rec_cnt, update last_served=can_rec_select, and return to IDLE.
REQ-023 Minimum spacing between two frames, with uplink_ready held high, SHALL be READ_LAT+3 cycles (IDLE, READ_LAT x READ, SEND, ACK).
REQ-024 If the served bus's irq_can_rec drops during READ or SEND, the frame SHALL still complete; the ack SHALL still be issued.
REQ-025 New or simultaneous irq assertions SHALL NOT preempt a frame in progress; they are arbitrated at the next IDLE.
REQ-026 can_rec_select SHALL hold its value through READ, SEND and ACK, and SHALL keep the last value in IDLE when no request is pending.
REQ-027 All outputs SHALL be registered; rec_ack SHALL never have more than one bit set.

Reset
REQ-028 On rst=0, asynchronously: state=IDLE, can_rec_select=0, rec_ack=0, data_rec_uplink=0, uplink_valid=0, busy=0, rec_cnt=0, last_served=31, READ counter=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame without issuing rec_ack; the pending irq SHALL be re-served after reset release.
REQ-030 The first arbitration SHALL occur no earlier than the first rising clk edge after rst deasserts.

Verification
REQ-031 Single frame: n_buses=31, irq_can_rec[5]=1, rec_data_in=76'hA_5A5A_5A5A_5A5A_5A5A_5A, ready=1 -> select=5, uplink_valid high after 1+READ_LAT cycles with that data, rec_ack=32'h20 one cycle, rec_cnt=1.
REQ-032 Round-robin: irq bits 0, 3 and 31 held high, ready=1 -> service order 0, 3, 31, 0, 3, with frames spaced READ_LAT+3 cycles.
REQ-033 Masking: n_buses=7, irq_can_rec=32'h8000_0100 -> no service and busy=0; then set bit 2 -> only bus 2 served.
REQ-034 Backpressure: ready=0 for 50 cycles after valid -> data and valid stable for 50 cycles, no ack; ready=1 -> one-cycle ack, then valid=0.
REQ-035 Reset mid-SEND: drop rst while valid=1 -> all outputs go to their REQ-028 values immediately with no ack; after release the same bus is served again.
REQ-036 Counter wrap: preload via 65536 frames or force rec_cnt=0xFFFF, then deliver one frame -> rec_cnt=0.

Source files
------------

// File: rtl/can_rec_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : can_rec_arbiter_if
//  Description : Bus bundle between the CAN receive arbiter, the per-bus CAN
//                controllers (irq/ack and the external frame mux), and the
//                e-link uplink transmitter.
//                  n_buses         - highest enabled bus index
//                  irq_can_rec     - per-bus "frame pending" levels
//                  rec_data_in     - frame of the bus selected by can_rec_select
//                  can_rec_select  - index of the bus being served
//                  rec_ack         - one-hot, one-cycle pending-flag clear
//                  data_rec_uplink - frame toward the e-link transmitter
//                  uplink_valid    - data_rec_uplink holds an unconsumed frame
//                  uplink_ready    - transmitter accepts a frame this cycle
//                  busy            - arbiter is not idle
//                  rec_cnt         - delivered-frame counter
//                The slave modport is the arbiter's view; master is the
//                surrounding system's view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface can_rec_arbiter_if;
    logic [4:0]  n_buses;
    logic [31:0] irq_can_rec;
    logic [75:0] rec_data_in;
    logic [4:0]  can_rec_select;
    logic [31:0] rec_ack;
    logic [75:0] data_rec_uplink;
    logic        uplink_valid;
    logic        uplink_ready;
    logic        busy;
    logic [15:0] rec_cnt;

    modport slave (
        input  n_buses,
        input  irq_can_rec,
        input  rec_data_in,
        input  uplink_ready,
        output can_rec_select,
        output rec_ack,
        output data_rec_uplink,
        output uplink_valid,
        output busy,
        output rec_cnt
    );

    modport master (
        output n_buses,
        output irq_can_rec,
        output rec_data_in,
        output uplink_ready,
        input  can_rec_select,
        input  rec_ack,
        input  data_rec_uplink,
        input  uplink_valid,
        input  busy,
        input  rec_cnt
    );
endinterface
`default_nettype wire

// File: rtl/can_rec_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : can_rec_arbiter
//  Description : Round-robin arbiter that drains received CAN frames from up
//                to 32 buses into a single e-link uplink. One frame at a time:
//                IDLE picks a bus, READ waits READ_LAT cycles for the external
//                mux, SEND holds the frame until the uplink accepts it, ACK
//                pulses the served bus's rec_ack and counts the frame.
//  Ports       : clk  - system clock
//                rst  - asynchronous, active-low reset
//                bus  - can_rec_arbiter_if.slave (see interface header)
//  Parameters  : READ_LAT - cycles from can_rec_select change to valid
//                           rec_data_in, legal range 1..15
//  Revision    : 1.0 - initial release
// ============================================================================
module can_rec_arbiter #(
    parameter int READ_LAT = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    can_rec_arbiter_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    localparam logic [3:0] c_LAT_LAST = 4'(READ_LAT - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [3:0]  r_rd_cnt;
    logic [4:0]  r_sel;
    logic [4:0]  r_last_served;
    logic [31:0] r_ack;
    logic [75:0] r_data;
    logic        r_valid;
    logic        r_busy;
    logic [15:0] r_rec_cnt;

    // ------------------------------------------------------------------------
    // Next-value wires
    // ------------------------------------------------------------------------
    logic [1:0]  w_state_nxt;
    logic [3:0]  w_rd_cnt_nxt;
    logic [4:0]  w_sel_nxt;
    logic [4:0]  w_last_nxt;
    logic [31:0] w_ack_nxt;
    logic [75:0] w_data_nxt;
    logic        w_valid_nxt;
    logic        w_busy_nxt;
    logic [15:0] w_rec_cnt_nxt;

    // ------------------------------------------------------------------------
    // Round-robin winner.
    // The search starts one above the last served bus and wraps at n_buses.
    // This is done as two priority encoders over the masked request vector:
    // the lowest request at or above the start point wins, otherwise the
    // lowest request below it. Because buses above n_buses are masked off,
    // that is the same as an upward search wrapping past n_buses to 0, and
    // the last served bus is naturally the final candidate. A last_served at
    // or above n_buses (reset value, or n_buses lowered) restarts at 0.
    // ------------------------------------------------------------------------
    logic [31:0] w_eligible;
    logic [4:0]  w_start;
    logic        w_hi_found;
    logic [4:0]  w_hi_idx;
    logic        w_lo_found;
    logic [4:0]  w_lo_idx;
    logic        w_any;
    logic [4:0]  w_winner;

    always_comb begin
        w_eligible = '0;
        w_hi_found = 1'b0;
        w_hi_idx   = 5'd0;
        w_lo_found = 1'b0;
        w_lo_idx   = 5'd0;
        w_start    = (r_last_served >= bus.n_buses) ? 5'd0 : (r_last_served + 5'd1);
        for (int i = 0; i < 32; i++) begin
            w_eligible[i] = bus.irq_can_rec[i] && (5'(i) <= bus.n_buses);
        end
        // Descending scan so the lowest qualifying index is written last.
        for (int i = 31; i >= 0; i--) begin
            if (w_eligible[i]) begin
                if (5'(i) >= w_start) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = 5'(i);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = 5'(i);
                end
            end
        end
        w_any    = w_hi_found || w_lo_found;
        w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_any)                    w_state_nxt = S_READ;
            S_READ: if (r_rd_cnt == c_LAT_LAST)   w_state_nxt = S_SEND;
            // uplink_valid is always high in SEND, so ready alone suffices.
            S_SEND: if (bus.uplink_ready)         w_state_nxt = S_ACK;
            S_ACK:                                w_state_nxt = S_IDLE;
            default:                              w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output / datapath next values (all outputs are registered)
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_cnt_nxt  = r_rd_cnt;
        w_sel_nxt     = r_sel;
        w_last_nxt    = r_last_served;
        w_ack_nxt     = '0;
        w_data_nxt    = r_data;
        w_valid_nxt   = r_valid;
        w_rec_cnt_nxt = r_rec_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_sel_nxt    = w_winner;
                    w_rd_cnt_nxt = 4'd0;
                end
            end
            S_READ: begin
                if (r_rd_cnt == c_LAT_LAST) begin
                    w_data_nxt   = bus.rec_data_in;
                    w_valid_nxt  = 1'b1;
                    w_rd_cnt_nxt = 4'd0;
                end else begin
                    w_rd_cnt_nxt = r_rd_cnt + 4'd1;
                end
            end
            S_SEND: begin
                // Acknowledge, count and rotate priority together so the ack
                // pulse is visible exactly during the ACK state.
                if (bus.uplink_ready) begin
                    w_valid_nxt   = 1'b0;
                    w_ack_nxt     = 32'h1 << r_sel;
                    w_rec_cnt_nxt = r_rec_cnt + 16'd1;
                    w_last_nxt    = r_sel;
                end
            end
            default: ;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_rd_cnt      <= 4'd0;
            r_sel         <= 5'd0;
            r_last_served <= 5'd31;
            r_ack         <= '0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_busy        <= 1'b0;
            r_rec_cnt     <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_rd_cnt      <= w_rd_cnt_nxt;
            r_sel         <= w_sel_nxt;
            r_last_served <= w_last_nxt;
            r_ack         <= w_ack_nxt;
            r_data        <= w_data_nxt;
            r_valid       <= w_valid_nxt;
            r_busy        <= w_busy_nxt;
            r_rec_cnt     <= w_rec_cnt_nxt;
        end
    end

    assign bus.can_rec_select  = r_sel;
    assign bus.rec_ack         = r_ack;
    assign bus.data_rec_uplink = r_data;
    assign bus.uplink_valid    = r_valid;
    assign bus.busy            = r_busy;
    assign bus.rec_cnt         = r_rec_cnt;

endmodule
`default_nettype wire

// File: tb/tb_can_rec_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_can_rec_arbiter
//  Description : Directed self-checking bench for can_rec_arbiter. The bench
//                models the external frame mux as a fixed function of
//                can_rec_select (optionally XORed with noise, or replaced by a
//                fixed frame) and plays the CAN controllers by hand.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_can_rec_arbiter;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        r_use_fixed;
    logic [75:0] r_fixed;
    logic [75:0] r_noise;
    int          checks;
    int          errors;

    can_rec_arbiter_if bif ();

    can_rec_arbiter #(.READ_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [75:0] frame_of(input logic [4:0] s);
        frame_of = {7'h55, s, 64'hC0DE_0000_0000_0000 | {59'h0, s}};
    endfunction

    assign bif.rec_data_in = r_use_fixed ? r_fixed : (frame_of(bif.can_rec_select) ^ r_noise);

    task automatic do_reset();
        bif.irq_can_rec  = '0;
        bif.uplink_ready = 1'b0;
        bif.n_buses      = 5'd31;
        r_use_fixed      = 1'b0;
        r_noise          = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_valid(input int max_cycles, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < max_cycles && !ok) begin
            @(negedge clk);
            n++;
            if (bif.uplink_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_ack(input int max_cycles, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < max_cycles && !ok) begin
            @(negedge clk);
            n++;
            if (bif.rec_ack !== 32'h0) ok = 1'b1;
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        bif.irq_can_rec  = '0;
        bif.uplink_ready = 1'b0;
        bif.n_buses      = 5'd31;
        r_use_fixed      = 1'b0;
        r_fixed          = '0;
        r_noise          = '0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bif.busy, bif.uplink_valid, bif.rec_ack, bif.can_rec_select} !== 39'h0) begin
            errors++;
            $display("FAIL reset_ctrl busy=%b valid=%b ack=%h sel=%0d required all 0",
                     bif.busy, bif.uplink_valid, bif.rec_ack, bif.can_rec_select);
        end
        checks++;
        if (bif.data_rec_uplink !== 76'h0 || bif.rec_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_data data=%h cnt=%h required 0/0", bif.data_rec_uplink, bif.rec_cnt);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_single();
        int n;
        bit ok;
        do_reset();
        r_use_fixed = 1'b1;
        r_fixed     = 76'hA_5A5A_5A5A_5A5A_5A5A_5A;
        bif.uplink_ready = 1'b1;
        bif.irq_can_rec  = 32'h0000_0020;
        wait_valid(20, n, ok);
        checks++;
        if (!ok || n != 1 + LAT) begin
            errors++;
            $display("FAIL single_latency ok=%b cycles=%0d required %0d", ok, n, 1 + LAT);
        end
        checks++;
        if (bif.can_rec_select !== 5'd5) begin
            errors++;
            $display("FAIL single_select got %0d required 5", bif.can_rec_select);
        end
        checks++;
        if (bif.data_rec_uplink !== 76'hA_5A5A_5A5A_5A5A_5A5A_5A) begin
            errors++;
            $display("FAIL single_data got %h required A5A5A5A5A5A5A5A5A5A", bif.data_rec_uplink);
        end
        @(negedge clk);
        checks++;
        if (bif.rec_ack !== 32'h20 || bif.uplink_valid !== 1'b0 || bif.rec_cnt !== 16'd1) begin
            errors++;
            $display("FAIL single_ack ack=%h valid=%b cnt=%0d required 20/0/1",
                     bif.rec_ack, bif.uplink_valid, bif.rec_cnt);
        end
        bif.irq_can_rec = '0;
        @(negedge clk);
        checks++;
        if (bif.rec_ack !== 32'h0 || bif.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after ack=%h busy=%b required 0/0", bif.rec_ack, bif.busy);
        end
        r_use_fixed = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_round_robin();
        int got[5];
        int t_ack[5];
        int exp_order[5] = '{0, 3, 31, 0, 3};
        int na;
        int cyc;
        do_reset();
        bif.uplink_ready = 1'b1;
        bif.irq_can_rec  = 32'h8000_0009;
        na  = 0;
        cyc = 0;
        while (na < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bif.uplink_valid === 1'b1) begin
                checks++;
                if (bif.data_rec_uplink !== frame_of(bif.can_rec_select)) begin
                    errors++;
                    $display("FAIL rr_data got %h required %h", bif.data_rec_uplink,
                             frame_of(bif.can_rec_select));
                end
            end
            if (bif.rec_ack !== 32'h0) begin
                checks++;
                if (bif.rec_ack !== (32'h1 << bif.can_rec_select)) begin
                    errors++;
                    $display("FAIL rr_onehot ack=%h sel=%0d", bif.rec_ack, bif.can_rec_select);
                end
                got[na]   = int'(bif.can_rec_select);
                t_ack[na] = cyc;
                na++;
            end
        end
        bif.irq_can_rec = '0;
        checks++;
        if (na != 5) begin
            errors++;
            $display("FAIL rr_count acks=%0d required 5", na);
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (got[k] != exp_order[k]) begin
                    errors++;
                    $display("FAIL rr_order[%0d] got %0d required %0d", k, got[k], exp_order[k]);
                end
                if (k > 0) begin
                    checks++;
                    if (t_ack[k] - t_ack[k-1] != LAT + 3) begin
                        errors++;
                        $display("FAIL rr_spacing[%0d] got %0d required %0d", k,
                                 t_ack[k] - t_ack[k-1], LAT + 3);
                    end
                end
            end
        end
        checks++;
        if (bif.rec_cnt !== 16'd5) begin
            errors++;
            $display("FAIL rr_cnt got %0d required 5", bif.rec_cnt);
        end
        repeat (LAT + 4) @(negedge clk);
        checks++;
        if (bif.busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle busy=%b required 0", bif.busy);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_masking();
        bit ok;
        do_reset();
        bif.n_buses      = 5'd7;
        bif.uplink_ready = 1'b1;
        bif.irq_can_rec  = 32'h8000_0100;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (bif.busy !== 1'b0 || bif.rec_ack !== 32'h0) begin
                errors++;
                $display("FAIL mask_idle cycle %0d busy=%b ack=%h required 0/0", k, bif.busy, bif.rec_ack);
            end
        end
        bif.irq_can_rec = 32'h8000_0104;
        wait_ack(20, ok);
        checks++;
        if (!ok || bif.rec_ack !== 32'h4 || bif.can_rec_select !== 5'd2) begin
            errors++;
            $display("FAIL mask_serve ok=%b ack=%h sel=%0d required 4/2", ok, bif.rec_ack, bif.can_rec_select);
        end
        bif.irq_can_rec = 32'h8000_0100;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (bif.busy !== 1'b0) begin
                errors++;
                $display("FAIL mask_after cycle %0d busy=%b required 0", k, bif.busy);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_backpressure();
        int n;
        bit ok;
        do_reset();
        bif.uplink_ready = 1'b0;
        bif.irq_can_rec  = 32'h0000_0200;
        wait_valid(20, n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_valid timeout valid=%b required 1", bif.uplink_valid);
        end
        // Disturb the mux output; the captured frame must not follow it.
        r_noise = 76'h1234_5678;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            checks++;
            if (bif.uplink_valid !== 1'b1 || bif.data_rec_uplink !== frame_of(5'd9) ||
                bif.rec_ack !== 32'h0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d valid=%b data=%h ack=%h required 1/%h/0",
                         k, bif.uplink_valid, bif.data_rec_uplink, bif.rec_ack, frame_of(5'd9));
            end
        end
        bif.uplink_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bif.rec_ack !== 32'h200 || bif.uplink_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_ack ack=%h valid=%b required 200/0", bif.rec_ack, bif.uplink_valid);
        end
        bif.irq_can_rec = '0;
        @(negedge clk);
        checks++;
        if (bif.rec_ack !== 32'h0) begin
            errors++;
            $display("FAIL bp_ack_pulse ack=%h required 0", bif.rec_ack);
        end
        r_noise = '0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_send();
        int n;
        bit ok;
        do_reset();
        bif.uplink_ready = 1'b0;
        bif.irq_can_rec  = 32'h0000_1000;
        wait_valid(20, n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_mid_valid timeout valid=%b required 1", bif.uplink_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bif.uplink_valid !== 1'b0 || bif.busy !== 1'b0 || bif.rec_ack !== 32'h0 ||
            bif.can_rec_select !== 5'd0 || bif.data_rec_uplink !== 76'h0 || bif.rec_cnt !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid_async valid=%b busy=%b ack=%h sel=%0d data=%h cnt=%0d required all 0",
                     bif.uplink_valid, bif.busy, bif.rec_ack, bif.can_rec_select,
                     bif.data_rec_uplink, bif.rec_cnt);
        end
        bif.uplink_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bif.rec_ack !== 32'h0 || bif.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_hold ack=%h busy=%b required 0/0", bif.rec_ack, bif.busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bif.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_release_early busy=%b required 0", bif.busy);
        end
        @(negedge clk);
        checks++;
        if (bif.busy !== 1'b1 || bif.can_rec_select !== 5'd12) begin
            errors++;
            $display("FAIL rst_reserve busy=%b sel=%0d required 1/12", bif.busy, bif.can_rec_select);
        end
        wait_ack(20, ok);
        checks++;
        if (!ok || bif.rec_ack !== 32'h1000 || bif.rec_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rst_reack ok=%b ack=%h cnt=%0d required 1000/1", ok, bif.rec_ack, bif.rec_cnt);
        end
        bif.irq_can_rec = '0;
        repeat (2) @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_wrap();
        bit ok;
        do_reset();
        @(negedge clk);
        force dut.r_rec_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_rec_cnt;
        @(negedge clk);
        checks++;
        if (bif.rec_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload got %h required FFFF", bif.rec_cnt);
        end
        bif.uplink_ready = 1'b1;
        bif.irq_can_rec  = 32'h0000_0002;
        wait_ack(20, ok);
        checks++;
        if (!ok || bif.rec_cnt !== 16'h0000 || bif.rec_ack !== 32'h2) begin
            errors++;
            $display("FAIL wrap_cnt ok=%b cnt=%h ack=%h required 0000/2", ok, bif.rec_cnt, bif.rec_ack);
        end
        bif.irq_can_rec = '0;
        repeat (2) @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_masking();
        test_backpressure();
        test_reset_mid_send();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
